// File: rtl/imem_loader_if.sv
// Signal bundle between the instruction-memory loader and its surroundings:
// load control, program ROM port, instruction-memory ports and CPU hold/status.
interface imem_loader_if #(
    parameter int unsigned BANK_W = 2
);
    logic                load_start;
    logic [BANK_W-1:0]   bank_sel;
    logic [3:0]          cpu_pc;
    logic [BANK_W+3:0]   rom_addr;
    logic [15:0]         rom_data;
    logic                imem_we;
    logic [3:0]          imem_waddr;
    logic [15:0]         imem_wdata;
    logic [3:0]          imem_raddr;
    logic [15:0]         imem_rdata;
    logic                cpu_hold;
    logic                busy;
    logic                done;
    logic                error;
    logic [3:0]          err_addr;

    // Environment side: requests loads, models ROM/memory, reads status.
    modport master (
        output load_start, bank_sel, cpu_pc, rom_data, imem_rdata,
        input  rom_addr, imem_we, imem_waddr, imem_wdata, imem_raddr,
               cpu_hold, busy, done, error, err_addr
    );

    // Loader side.
    modport slave (
        input  load_start, bank_sel, cpu_pc, rom_data, imem_rdata,
        output rom_addr, imem_we, imem_waddr, imem_wdata, imem_raddr,
               cpu_hold, busy, done, error, err_addr
    );
endinterface

// File: rtl/imem_loader.sv
// Copies a 16-word program bank from ROM into instruction memory, then reads
// it back and compares against ROM, stalling the CPU for the whole operation.
module imem_loader #(
    parameter int unsigned BANK_W = 2
) (
    input logic          clk,
    input logic          rst,
    imem_loader_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        VERIFY,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic              error_q, error_d;
    logic [3:0]        err_addr_q, err_addr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bank_q     <= '0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bank_q     <= bank_d;
            error_q    <= error_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bank_d         = bank_q;
        error_d        = error_q;
        err_addr_d     = err_addr_q;
        bus.rom_addr   = {bank_q, 4'd0};
        bus.imem_we    = 1'b0;
        bus.imem_waddr = '0;
        bus.imem_wdata = '0;
        bus.imem_raddr = cnt_q;
        bus.cpu_hold   = 1'b1;
        bus.busy       = 1'b1;
        bus.done       = 1'b0;

        case (state_q)
            IDLE: begin
                bus.cpu_hold   = 1'b0;
                bus.busy       = 1'b0;
                bus.imem_raddr = bus.cpu_pc;
                if (bus.load_start) begin
                    bank_d     = bus.bank_sel;
                    cnt_d      = '0;
                    error_d    = 1'b0;
                    err_addr_d = '0;
                    state_d    = FILL;
                end
            end

            FILL: begin
                bus.rom_addr   = {bank_q, cnt_q};
                bus.imem_we    = 1'b1;
                bus.imem_waddr = cnt_q;
                bus.imem_wdata = bus.rom_data;
                cnt_d          = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = VERIFY;
                end
            end

            VERIFY: begin
                bus.rom_addr = {bank_q, cnt_q};
                // Stop at the first mismatch; cnt is frozen at the failing word.
                if (bus.imem_rdata != bus.rom_data) begin
                    error_d    = 1'b1;
                    err_addr_d = cnt_q;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.error    = error_q;
    assign bus.err_addr = err_addr_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: ROM and instruction memory are modelled
// as arrays, expectations follow the per-cycle load timeline.
module tb_imem_loader;

    logic clk;
    logic rst;

    imem_loader_if #(.BANK_W(2)) bus ();

    imem_loader #(.BANK_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] rom  [64];
    logic [15:0] imem [16];
    int          corrupt_addr = 16;

    assign bus.rom_data   = rom[bus.rom_addr];
    assign bus.imem_rdata = imem[bus.imem_raddr];

    // Memory that flips bits on writes to corrupt_addr (16 = healthy memory).
    always @(posedge clk) begin
        if (bus.imem_we) begin
            imem[bus.imem_waddr] <= bus.imem_wdata
                ^ ((int'(bus.imem_waddr) == corrupt_addr) ? 16'h0101 : 16'h0000);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    int exp_bank     = 0;
    bit exp_err      = 1'b0;
    int exp_err_addr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One IDLE cycle with load_start low; pc < 0 picks a random fetch address.
    task automatic idle_cycle(input int pc);
        load_start_drive(1'b0, 2'($urandom));
        bus.cpu_pc = (pc < 0) ? 4'($urandom) : 4'(pc);
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 0);
        check("idle_hold", 32'(bus.cpu_hold), 0);
        check("idle_we", 32'(bus.imem_we), 0);
        check("idle_done", 32'(bus.done), 0);
        check("idle_raddr", 32'(bus.imem_raddr), 32'(bus.cpu_pc));
        check("idle_waddr", 32'(bus.imem_waddr), 0);
        check("idle_wdata", 32'(bus.imem_wdata), 0);
        check("idle_romaddr", 32'(bus.rom_addr), 32'(exp_bank * 16));
        check("idle_error", 32'(bus.error), 32'(exp_err));
        if (exp_err) check("idle_erraddr", 32'(bus.err_addr), 32'(exp_err_addr));
        @(posedge clk);
        #1;
    endtask

    task automatic load_start_drive(input logic ls, input logic [1:0] bs);
        bus.load_start = ls;
        bus.bank_sel   = bs;
    endtask

    // Cycle 0 is the accepting IDLE cycle; FILL 1-16, VERIFY from 17, DONE
    // at 33 or one cycle after the failing compare.
    task automatic run_load(input int b, input int corrupt, input bit hold_start,
                            input int glitch_cyc, input int rst_cyc);
        int done_cyc;
        int last;
        int bad;
        bit fill, ver, dn;
        done_cyc     = (corrupt < 16) ? 18 + corrupt : 33;
        last         = (rst_cyc >= 0) ? rst_cyc : done_cyc;
        corrupt_addr = corrupt;
        for (int c = 0; c <= last; c++) begin
            if (c == 0)
                load_start_drive(1'b1, 2'(b));
            else if (c == glitch_cyc)
                load_start_drive(1'b1, (b == 1) ? 2'd0 : 2'd1);
            else
                load_start_drive(hold_start, 2'($urandom));
            rst        = (c == rst_cyc);
            bus.cpu_pc = 4'($urandom);
            @(negedge clk);
            if (c == 0) begin
                check("acc_busy", 32'(bus.busy), 0);
                check("acc_raddr", 32'(bus.imem_raddr), 32'(bus.cpu_pc));
                check("acc_error", 32'(bus.error), 32'(exp_err));
            end else begin
                fill = (c <= 16);
                ver  = (c >= 17) && (c < done_cyc);
                dn   = (c == done_cyc);
                check("busy", 32'(bus.busy), 1);
                check("hold", 32'(bus.cpu_hold), 1);
                check("done", 32'(bus.done), 32'(dn));
                check("we", 32'(bus.imem_we), 32'(fill));
                check("waddr", 32'(bus.imem_waddr), fill ? 32'(c - 1) : 0);
                check("wdata", 32'(bus.imem_wdata), fill ? 32'(rom[b * 16 + c - 1]) : 0);
                check("romaddr", 32'(bus.rom_addr),
                      fill ? 32'(b * 16 + c - 1) : ver ? 32'(b * 16 + c - 17) : 32'(b * 16));
                if (fill) check("raddr_fill", 32'(bus.imem_raddr), 32'(c - 1));
                if (ver)  check("raddr_ver", 32'(bus.imem_raddr), 32'(c - 17));
                if (c < done_cyc) begin
                    check("error_run", 32'(bus.error), 0);
                end else begin
                    check("error_end", 32'(bus.error), 32'(corrupt < 16));
                    check("erraddr_end", 32'(bus.err_addr), (corrupt < 16) ? 32'(corrupt) : 0);
                end
            end
            @(posedge clk);
            #1;
        end
        if (rst_cyc >= 0) begin
            rst          = 1'b0;
            exp_bank     = 0;
            exp_err      = 1'b0;
            exp_err_addr = 0;
        end else begin
            exp_bank     = b;
            exp_err      = (corrupt < 16);
            exp_err_addr = (corrupt < 16) ? corrupt : 0;
            bad = 0;
            for (int k = 0; k < 16; k++) if (imem[k] !== rom[b * 16 + k]) bad++;
            check("mem_contents", 32'(bad), (corrupt < 16) ? 1 : 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 16'($urandom);
        for (int k = 0; k < 16; k++) rom[32 + k] = 16'hA000 + 16'(k);
        for (int k = 0; k < 16; k++) imem[k] = '0;

        // Reset wins over a simultaneous load request.
        rst = 1'b1;
        load_start_drive(1'b1, 2'd3);
        bus.cpu_pc = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycle(-1);
        idle_cycle(9);

        run_load(2, 16, 1'b0, -1, -1);
        idle_cycle(-1);
        run_load(2, 5, 1'b0, -1, -1);
        idle_cycle(-1);
        idle_cycle(-1);
        run_load(2, 16, 1'b0, 10, -1);
        idle_cycle(-1);
        run_load(3, 16, 1'b0, -1, 8);
        idle_cycle(-1);
        run_load(0, 16, 1'b0, -1, -1);
        idle_cycle(-1);

        // load_start held high: second load accepted right after done.
        run_load(1, int'($urandom_range(0, 15)), 1'b1, -1, -1);
        run_load(3, 16, 1'b0, -1, -1);
        idle_cycle(-1);

        for (int n = 0; n < 6; n++) begin
            run_load(int'($urandom_range(0, 3)),
                     ($urandom_range(0, 1) == 1) ? 16 : int'($urandom_range(0, 15)),
                     1'b0, -1, -1);
            idle_cycle(-1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
